apx_err_accum: RTL and testbench

- Streaming error-statistics stage sitting directly downstream of the approximate integer adders (bta_trunc, bta, acc_adder).
- Consumes pairs of accurate-adder and approximate-adder results and computes signed error distance per pair.
- Accumulates mismatch count, saturating sum of absolute error and maximum absolute error over a programmed number of samples.
- Presents the result through a valid/ready handshake; replaces offline post-processing of dumped adder outputs.

---
 rtl/apx_err_pkg.sv | 30 +++
 rtl/apx_err_diff_stage.sv | 40 ++++
 rtl/apx_err_accum.sv | 130 +++++++++++++
 tb/tb_apx_err_accum.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/apx_err_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apx_err_pkg : shared types, widths and saturating add for error stats |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package apx_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned C_WIDTH = 32;
  localparam int unsigned C_CNT_W = 16;
  localparam int unsigned C_SUM_W = 48;

  // Adds two values of up to 64 bits and clamps at the all-ones value of width w (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? m[63:0] : s[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/apx_err_diff_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apx_err_diff_stage : registered signed difference acc - apx + valid |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module apx_err_diff_stage
  import apx_err_pkg::*;
#(
  parameter int unsigned WIDTH = C_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_apx,
  output logic             o_valid,
  output logic [WIDTH:0]   o_diff
);

  logic           r_valid;
  logic [WIDTH:0] r_diff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
    end else begin
      r_valid <= i_valid;
      // One extra bit keeps the full difference range without overflow.
      if (i_valid) begin
        r_diff <= {i_acc[WIDTH-1], i_acc} - {i_apx[WIDTH-1], i_apx};
      end
    end
  end

  assign o_valid = r_valid;
  assign o_diff  = r_diff;

endmodule
`default_nettype wire

// File: rtl/apx_err_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apx_err_accum : streaming error statistics for approximate adders  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module apx_err_accum
  import apx_err_pkg::*;
#(
  parameter int unsigned WIDTH = C_WIDTH,
  parameter int unsigned CNT_W = C_CNT_W,
  parameter int unsigned SUM_W = C_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_acc,
  input  logic [WIDTH-1:0] in_apx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_sample_cnt,
  output logic [CNT_W-1:0] out_mismatch_cnt,
  output logic [SUM_W-1:0] out_err_sum,
  output logic [WIDTH-1:0] out_err_max,
  output logic             busy
);

  state_e           r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic [SUM_W-1:0] r_err_sum;
  logic [WIDTH-1:0] r_err_max;

  logic             w_accept;
  logic             w_s1_valid;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_abs;
  logic [SUM_W-1:0] w_sum_next;

  assign w_accept = in_valid && (r_state == ST_RUN);

  apx_err_diff_stage #(
    .WIDTH(WIDTH)
  ) u_diff (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept),
    .i_acc   (in_acc),
    .i_apx   (in_apx),
    .o_valid (w_s1_valid),
    .o_diff  (w_diff)
  );

  // |diff| never exceeds 2^WIDTH-1, so dropping the top bit after negation is exact.
  assign w_abs      = w_diff[WIDTH] ? WIDTH'(-w_diff) : w_diff[WIDTH-1:0];
  assign w_sum_next = SUM_W'(sat_add(64'(r_err_sum), 64'(w_abs), SUM_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_n            <= '0;
      r_acc_cnt      <= '0;
      r_out_valid    <= 1'b0;
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_err_sum      <= '0;
      r_err_max      <= '0;
    end else begin
      if (w_s1_valid) begin
        r_sample_cnt   <= r_sample_cnt + CNT_W'(1);
        r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(w_diff != '0);
        r_err_sum      <= w_sum_next;
        if (w_abs > r_err_max) r_err_max <= w_abs;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n            <= num_samples;
            r_acc_cnt      <= '0;
            r_sample_cnt   <= '0;
            r_mismatch_cnt <= '0;
            r_err_sum      <= '0;
            r_err_max      <= '0;
            if (num_samples == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            if (r_acc_cnt == r_n - CNT_W'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Stage 2 folds the last sample on the edge stage 1 empties.
          if (!w_s1_valid) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready         = (r_state == ST_RUN);
  assign busy             = (r_state != ST_IDLE);
  assign out_valid        = r_out_valid;
  assign out_sample_cnt   = r_sample_cnt;
  assign out_mismatch_cnt = r_mismatch_cnt;
  assign out_err_sum      = r_err_sum;
  assign out_err_max      = r_err_max;

endmodule
`default_nettype wire

// File: tb/tb_apx_err_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apx_err_accum : directed + random bench, SUM_W=48 and SUM_W=33   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_apx_err_accum;

  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int SWA = 48;
  localparam int SWB = 33;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_acc = '0;
  logic [W-1:0]  in_apx = '0;
  logic          out_ready = 1'b0;

  logic           a_in_ready, a_out_valid, a_busy;
  logic [CW-1:0]  a_cnt, a_mis;
  logic [SWA-1:0] a_sum;
  logic [W-1:0]   a_max;
  logic           b_in_ready, b_out_valid, b_busy;
  logic [CW-1:0]  b_cnt, b_mis;
  logic [SWB-1:0] b_sum;
  logic [W-1:0]   b_max;

  apx_err_accum #(.WIDTH(W), .CNT_W(CW), .SUM_W(SWA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_acc(in_acc), .in_apx(in_apx),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sample_cnt(a_cnt), .out_mismatch_cnt(a_mis), .out_err_sum(a_sum),
    .out_err_max(a_max), .busy(a_busy)
  );

  apx_err_accum #(.WIDTH(W), .CNT_W(CW), .SUM_W(SWB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_acc(in_acc), .in_apx(in_apx),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sample_cnt(b_cnt), .out_mismatch_cnt(b_mis), .out_err_sum(b_sum),
    .out_err_max(b_max), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  longint unsigned m_cnt, m_mis, m_sum, m_max;
  logic [W-1:0] q_acc[$];
  logic [W-1:0] q_apx[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned abs_err(input logic [W-1:0] a, input logic [W-1:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d < 0) ? longint'(-d) : longint'(d);
  endfunction

  function automatic longint unsigned clamp(input longint unsigned v, input int w);
    longint unsigned lim;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_stats(input string tag);
    chk({tag, ".a_cnt"}, 64'(a_cnt), m_cnt);
    chk({tag, ".a_mis"}, 64'(a_mis), m_mis);
    chk({tag, ".a_sum"}, 64'(a_sum), clamp(m_sum, SWA));
    chk({tag, ".a_max"}, 64'(a_max), m_max);
    chk({tag, ".b_cnt"}, 64'(b_cnt), m_cnt);
    chk({tag, ".b_sum"}, 64'(b_sum), clamp(m_sum, SWB));
    chk({tag, ".b_max"}, 64'(b_max), m_max);
  endtask

  // gap < 0 means a random 0..2 idle cycles before each sample.
  task automatic do_run(input string tag, input int n, input int gap, input int hold);
    int g;
    m_cnt = 0; m_mis = 0; m_sum = 0; m_max = 0;
    start = 1'b1;
    num_samples = CW'(n);
    step();
    start = 1'b0;
    if (n != 0) begin
      chk({tag, ".run_ready"}, 64'(a_in_ready), 64'd1);
      for (int i = 0; i < n; i++) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_acc = $urandom;
          in_apx = $urandom;
          step();
          chk({tag, ".gap_busy"}, 64'(a_in_ready), 64'd1);
        end
        chk({tag, ".pre_accept_ready"}, 64'(b_in_ready), 64'd1);
        in_valid = 1'b1;
        in_acc = q_acc[i];
        in_apx = q_apx[i];
        m_cnt++;
        if (q_acc[i] != q_apx[i]) m_mis++;
        m_sum += abs_err(q_acc[i], q_apx[i]);
        if (abs_err(q_acc[i], q_apx[i]) > m_max) m_max = abs_err(q_acc[i], q_apx[i]);
        step();
        in_valid = 1'b0;
      end
      chk({tag, ".drain_ready"}, 64'(a_in_ready), 64'd0);
      chk({tag, ".e0_valid"}, 64'(a_out_valid), 64'd0);
      step();
      chk({tag, ".e1_valid"}, 64'(a_out_valid), 64'd0);
      step();
    end
    chk({tag, ".done_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, ".done_valid_b"}, 64'(b_out_valid), 64'd1);
    chk({tag, ".done_busy"}, 64'(a_busy), 64'd1);
    check_stats({tag, ".done"});
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      num_samples = CW'(7);
      step();
      start = 1'b0;
      chk({tag, ".hold_valid"}, 64'(a_out_valid), 64'd1);
      check_stats({tag, ".hold"});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".idle_valid"}, 64'(a_out_valid), 64'd0);
    chk({tag, ".idle_busy"}, 64'(b_busy), 64'd0);
    check_stats({tag, ".idle"});
    q_acc.delete();
    q_apx.delete();
  endtask

  initial begin
    int n;
    logic [W-1:0] v;
    step();
    step();
    chk("rst.valid", 64'(a_out_valid), 64'd0);
    chk("rst.busy", 64'(a_busy), 64'd0);
    chk("rst.ready", 64'(a_in_ready), 64'd0);
    chk("rst.sum", 64'(a_sum), 64'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin q_acc.push_back(32'd5); q_apx.push_back(32'd5); end
    do_run("eq4", 4, 0, 1);

    q_acc = '{32'd10, 32'd7, 32'hFFFF_FFFF};
    q_apx = '{32'd7, 32'd10, 32'h0000_0001};
    do_run("mix3", 3, 0, 0);

    q_acc = '{32'h7FFF_FFFF};
    q_apx = '{32'h8000_0000};
    do_run("ext1", 1, 0, 0);

    q_acc = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    q_apx = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    do_run("sat3", 3, 0, 0);

    for (int i = 0; i < 5; i++) begin q_acc.push_back($urandom); q_apx.push_back($urandom); end
    do_run("bp5", 5, 1, 5);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        v = $urandom;
        q_acc.push_back(v);
        case ($urandom_range(0, 3))
          0:       q_apx.push_back(v);
          1:       q_apx.push_back(v ^ 32'h8000_0000);
          2:       q_apx.push_back(v + W'($urandom_range(0, 15)));
          default: q_apx.push_back($urandom);
        endcase
      end
      do_run("rand", n, -1, int'($urandom_range(0, 3)));
    end

    // Abort a run part way with nonzero statistics already folded in.
    start = 1'b1;
    num_samples = CW'(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_acc = 32'd100;
      in_apx = 32'd1;
      step();
    end
    in_valid = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    chk("abort.ready", 64'(a_in_ready), 64'd0);
    chk("abort.busy", 64'(a_busy), 64'd0);
    chk("abort.valid", 64'(a_out_valid), 64'd0);
    chk("abort.cnt", 64'(a_cnt), 64'd0);
    chk("abort.mis", 64'(a_mis), 64'd0);
    chk("abort.sum", 64'(a_sum), 64'd0);
    chk("abort.max", 64'(a_max), 64'd0);
    step();
    rst = 1'b1;
    step();
    do_run("n0", 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
